// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues credit-limited requests to imem,
// buffers in-order responses and hands {addr, word} pairs to decode; redirect flushes.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] instruction_addr,
  output logic [DATA_WIDTH-1:0] instruction
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         count;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         stale;
  logic [CW-1:0]         outstanding_next;
  logic [CW:0]           used;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         aq_rd;
  logic [PW-1:0]         aq_wr;
  logic [ADDR_WIDTH-1:0] aq_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  req_fire;
  logic                  keep;
  logic                  pop;
  logic                  unused_redirect_lsbs;

  // Buffered plus in-flight never exceeds DEPTH, so every live response has a slot.
  assign used           = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign keep = imem_resp_valid && (stale == '0) && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

  assign id_valid         = (count != '0);
  assign instruction_addr = addr_mem[rd_ptr];
  assign instruction      = data_mem[rd_ptr];

  assign unused_redirect_lsbs = ^redirect_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      stale       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
    end else begin
      // The address queue tracks every accepted request, flushed or not.
      outstanding <= outstanding_next;
      aq_wr       <= aq_wr + PW'(req_fire);
      aq_rd       <= aq_rd + PW'(imem_resp_valid);
      if (redirect_valid) begin
        pc     <= {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        stale  <= outstanding_next;
      end else begin
        if (req_fire) pc <= pc + ADDR_WIDTH'(4);
        if (imem_resp_valid && (stale != '0)) stale <= stale - CW'(1);
        wr_ptr <= wr_ptr + PW'(keep);
        rd_ptr <= rd_ptr + PW'(pop);
        count  <= count + CW'(keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) aq_mem[aq_wr] <= pc;
    if (keep) begin
      addr_mem[wr_ptr] <= aq_mem[aq_rd];
      data_mem[wr_ptr] <= imem_resp_data;
    end
  end

endmodule
